// File: rtl/modrm_access_ctrl_if.sv
// Signal bundle between the ModR/M access sequencer and its environment
// (decoder fields, ALU handshake, memory port, EIP length report).
interface modrm_access_ctrl_if;
  logic        start;
  logic        op_rd;
  logic        op_wb;
  logic [1:0]  mod;
  logic [2:0]  m;
  logic [31:0] m_reg;
  logic [31:0] m_reg_plus_imm8;
  logic [31:0] m_reg_plus_imm32;
  logic [31:0] modrm_imm32;
  logic        alu_valid;
  logic [31:0] alu_result;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        opnd_valid;
  logic [31:0] rm_value;
  logic        reg_we;
  logic [2:0]  reg_idx;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  modrm_len;
  logic        done;
  logic        err;
  logic [2:0]  state_dbg;

  // Environment side (decoder, ALU, memory, EIP logic).
  modport master (
    output start, op_rd, op_wb, mod, m, m_reg, m_reg_plus_imm8, m_reg_plus_imm32,
           modrm_imm32, alu_valid, alu_result, mem_ack, mem_rdata,
    input  busy, opnd_valid, rm_value, reg_we, reg_idx, mem_req, mem_we, mem_addr,
           mem_wdata, modrm_len, done, err, state_dbg
  );

  // Sequencer side.
  modport slave (
    input  start, op_rd, op_wb, mod, m, m_reg, m_reg_plus_imm8, m_reg_plus_imm32,
           modrm_imm32, alu_valid, alu_result, mem_ack, mem_rdata,
    output busy, opnd_valid, rm_value, reg_we, reg_idx, mem_req, mem_we, mem_addr,
           mem_wdata, modrm_len, done, err, state_dbg
  );
endinterface

// File: rtl/modrm_access_ctrl.sv
// Sequencer for one ModR/M r/m operand access: fetch, ALU handoff, write-back.
// Optional memory-ack watchdog enabled by defining MODRM_ACC_TIMEOUT_EN.
module modrm_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                clk,
    input logic                rst,
    modrm_access_ctrl_if.slave bus
);

    // Handshakes: mem_req/mem_ack and opnd_valid/alu_valid complete on the first
    // rising edge where both are high; request-side outputs hold until then.
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_ALU, S_REGW, S_WR, S_DONE, S_ERR
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  mod_q;
    logic [2:0]  m_q;
    logic        wb_q;
    logic [31:0] addr_q, rm_q, wdata_q;
    logic [2:0]  len_q;
    logic [31:0] ea;
    logic [2:0]  len;
    logic        accept, is_sib, mem_phase, tmo;

    assign accept    = (state == S_IDLE) && bus.start;
    assign is_sib    = (bus.mod != 2'b11) && (bus.m == 3'b100);
    assign mem_phase = (state == S_RD) || (state == S_WR);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MODRM_ACC_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo = mem_phase && !bus.mem_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 tmo_cnt <= '0;
        else if (mem_phase && !bus.mem_ack && !tmo) tmo_cnt <= tmo_cnt + TMO_W'(1);
        else                                     tmo_cnt <= '0;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        ea  = bus.m_reg;
        len = 3'd2;
        case (bus.mod)
            2'b00: if (bus.m == 3'b101) begin
                ea  = bus.modrm_imm32;
                len = 3'd6;
            end
            2'b01: begin ea = bus.m_reg_plus_imm8;  len = 3'd3; end
            2'b10: begin ea = bus.m_reg_plus_imm32; len = 3'd6; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) begin
                if (is_sib)                            state_nxt = S_ERR;
                else if (!bus.op_rd && !bus.op_wb)     state_nxt = S_DONE;
                else if (bus.op_rd && bus.mod != 2'b11) state_nxt = S_RD;
                else                                   state_nxt = S_ALU;
            end
            S_RD:   if (bus.mem_ack) state_nxt = S_ALU;
                    else if (tmo)    state_nxt = S_ERR;
            S_ALU:  if (bus.alu_valid) begin
                if (!wb_q)               state_nxt = S_DONE;
                else if (mod_q == 2'b11) state_nxt = S_REGW;
                else                     state_nxt = S_WR;
            end
            S_REGW: state_nxt = S_DONE;
            S_WR:   if (bus.mem_ack) state_nxt = S_DONE;
                    else if (tmo)    state_nxt = S_ERR;
            S_DONE, S_ERR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state != S_IDLE);
        bus.opnd_valid = (state == S_ALU);
        bus.reg_we     = (state == S_REGW);
        bus.mem_req    = mem_phase;
        bus.mem_we     = (state == S_WR);
        bus.done       = (state == S_DONE) || (state == S_ERR);
        bus.err        = (state == S_ERR);
        bus.state_dbg  = state;
    end

    // Operand registers hold across the access and until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mod_q   <= '0;
            m_q     <= '0;
            wb_q    <= 1'b0;
            addr_q  <= '0;
            rm_q    <= '0;
            wdata_q <= '0;
            len_q   <= '0;
        end else begin
            if (accept) begin
                mod_q  <= bus.mod;
                m_q    <= bus.m;
                wb_q   <= bus.op_wb;
                addr_q <= ea;
                len_q  <= len;
                rm_q   <= (bus.op_rd && bus.mod == 2'b11) ? bus.m_reg : 32'd0;
            end
            if (state == S_RD && bus.mem_ack)     rm_q    <= bus.mem_rdata;
            if (state == S_ALU && bus.alu_valid)  wdata_q <= bus.alu_result;
        end
    end

    assign bus.rm_value  = rm_q;
    assign bus.reg_idx   = m_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.modrm_len = len_q;

endmodule
